dm_port_arbiter: RTL and testbench
==================================

# dm_port_arbiter

Two-requester arbiter and sequencer for the single-ported unified memory behind the pipeline. It shares one memory port between the MEM stage data port (requester D) and the instruction-fetch port (requester I). It issues one transaction at a time, waits a fixed memory latency, and returns read data with a one-cycle acknowledge. Pipeline stalls are derived from the request/acknowledge pair it exports.

## Interface
Parameters:
- LATENCY, 2, cycles from the memory issue cycle to valid m_rdata; legal range 1..15.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset, asynchronous, active-low.
- d_req  in  1  D request; held with fields stable until d_ack.
- d_write  in  1  D store (1) / load (0).
- d_addr  in  32  D address, passed through unmodified.
- d_wdata  in  32  D store data.
- d_size  in  2  D store size: 0 word, 1 byte, 2 half.
- d_ack  out  1  one-cycle completion pulse for D.
- d_rdata  out  32  D load data, registered, valid with d_ack and held after.
- d_stall  out  1  d_req & ~d_ack (combinational).
- i_req  in  1  I fetch request; held until i_ack.
- i_addr  in  32  I fetch address.
- i_ack  out  1  one-cycle completion pulse for I.
- i_rdata  out  32  fetched word, registered, valid with i_ack and held after.
- i_stall  out  1  i_req & ~i_ack.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_size  out  2  memory write size (0 for all reads and I fetches).
- m_read  out  1  one-cycle read strobe.
- m_write  out  1  one-cycle write strobe.
- m_rdata  in  32  memory read data, valid LATENCY cycles after the strobe cycle.
- owner  out  1  requester owning the port: 0 D, 1 I; meaningful while not IDLE.

## Operation
- The FSM has three states: IDLE, ISSUE and WAIT. A down-counter cnt is 4 bits wide.
- IDLE behaviour:
  - Eligibility is e_d = d_req & ~d_ack and e_i = i_req & ~i_ack.
  - The ack mask prevents re-granting a request whose ack is in flight this cycle.
  - If only one requester is eligible, it wins.
  - If both are eligible, the winner is the requester opposite last_grant (round-robin).
  - On a win, the next state is ISSUE and owner and last_grant are set to the winner.
  - m_addr, m_wdata and m_size are registered from the winner. For I, m_wdata=0 and m_size=0.
- ISSUE lasts exactly one cycle.
  - m_read=~wr or m_write=wr is high.
  - cnt is loaded with LATENCY.
  - The next state is WAIT.
- WAIT behaviour:
  - cnt decrements each cycle.
  - At the edge where cnt==1, the owner's rdata register captures m_rdata. This happens for writes too; the value is don't-care.
  - At the same edge, the owner's ack is pulsed high for the following cycle and the state returns to IDLE.
- Stores and loads share identical timing. Stores are acknowledged, not posted.
- m_addr, m_wdata and m_size hold from ISSUE until the next grant.
- If a requester drops req mid-transaction, the transaction still completes and ack still pulses. The requester ignores it.
- The I port never writes.

## Timing
- Reset values:
  - state=IDLE, cnt=0, owner=0, last_grant=1 (D wins the first conflict).
  - All m_* outputs are 0.
  - d_ack, i_ack, d_rdata and i_rdata are 0.
- RESET asserted mid-transaction aborts it: no ack is generated and the strobes are forced to 0 immediately.
- Latency, with req first high in IDLE cycle c:
  - ISSUE occurs in cycle c+1.
  - m_rdata is valid in cycle c+1+LATENCY.
  - ack is high in cycle c+LATENCY+2.
- Occupancy is LATENCY+1 cycles per transaction.
- Back-to-back operation:
  - The ack cycle is an IDLE cycle, so the other requester can be granted in it. Its ISSUE follows in the next cycle.
  - For the same requester, a new request is first eligible in the cycle after its ack.
- Under continuous contention, grants alternate D, I, D, I. Neither requester waits more than one transaction.
- LATENCY=1: WAIT lasts one cycle.

## Structure
- Shared package dm_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT);
  - requester IDs REQ_D=0 and REQ_I=1;
  - size constants SZ_WORD=0, SZ_BYTE=1, SZ_HALF=2.
- One sub-module, dm_rr_pick2: a combinational 2-way round-robin picker.
  - Inputs: e_d, e_i, last_grant.
  - Outputs: valid and winner.
- The FSM, counter and registers live in the top module.

## Test plan
- Single D load (LATENCY=2):
  - Stimulus: d_req=1, d_addr=0x100 at cycle 0; memory returns 0xDEADBEEF.
  - Expected: m_read=1 and m_addr=0x100 in cycle 1; d_ack in cycle 4 with d_rdata=0xDEADBEEF; d_stall high in cycles 0–3.
- D byte store:
  - Stimulus: d_write=1, d_size=1, d_wdata=0xAB.
  - Expected: m_write=1 for one cycle with m_size=1 and m_wdata=0xAB; m_read stays 0; d_ack arrives 4 cycles after the request.
- Simultaneous first requests:
  - Stimulus: D and I both request in cycle 0.
  - Expected: D is issued in cycle 1; d_ack in cycle 4; I is issued in cycle 5; i_ack in cycle 8.
- Continuous contention over 6 transactions:
  - Expected: owner sequence is D, I, D, I, D, I; no two consecutive ISSUEs belong to the same requester.
- Reset mid-WAIT:
  - Stimulus: drop RESET while in WAIT.
  - Expected: all outputs 0 immediately; no ack after release; the held request restarts from ISSUE.
- LATENCY=1 sweep:
  - Stimulus: I fetch of address 0x400.
  - Expected: i_ack in cycle c+3; i_rdata equals the word at 0x400.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package dm_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam logic REQ_D = 1'b0;
    localparam logic REQ_I = 1'b1;

    localparam logic [SIZE_W-1:0] SZ_WORD = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'd2;

    // Memory command payload held on the m_* port from ISSUE until the next grant.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SIZE_W-1:0] size;
    } mem_cmd_t;

endpackage

// File: rtl/dm_rr_pick2.sv
// Two-way round-robin picker: on conflict, the requester opposite last_grant wins.
module dm_rr_pick2
    import dm_arb_pkg::*;
(
    input  logic e_d,
    input  logic e_i,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = e_d | e_i;
        winner = REQ_D;
        if (e_d && e_i) begin
            winner = ~last_grant;
        end else if (e_i) begin
            winner = REQ_I;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares one fixed-latency memory port between the D (MEM stage) and I (fetch) requesters,
// one transaction at a time, with a one-cycle acknowledge per completion.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [SIZE_W-1:0] d_size,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [SIZE_W-1:0] m_size,
    output logic              m_read,
    output logic              m_write,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              owner
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic              m_read_q, m_read_d;
    logic              m_write_q, m_write_d;
    logic              d_ack_q, d_ack_d;
    logic              i_ack_q, i_ack_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;

    logic e_d, e_i, pick_valid, pick_winner;

    // A request whose ack is on the wire this cycle must not be granted again.
    assign e_d = d_req & ~d_ack_q;
    assign e_i = i_req & ~i_ack_q;

    dm_rr_pick2 u_pick (
        .e_d        (e_d),
        .e_i        (e_i),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= REQ_D;
            last_grant_q <= REQ_I;
            cmd_q        <= '0;
            m_read_q     <= 1'b0;
            m_write_q    <= 1'b0;
            d_ack_q      <= 1'b0;
            i_ack_q      <= 1'b0;
            d_rdata_q    <= '0;
            i_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cmd_q        <= cmd_d;
            m_read_q     <= m_read_d;
            m_write_q    <= m_write_d;
            d_ack_q      <= d_ack_d;
            i_ack_q      <= i_ack_d;
            d_rdata_q    <= d_rdata_d;
            i_rdata_q    <= i_rdata_d;
        end
    end

    // Next-state: strobes are registered on the grant so they appear in the ISSUE cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cmd_d        = cmd_q;
        m_read_d     = 1'b0;
        m_write_d    = 1'b0;
        d_ack_d      = 1'b0;
        i_ack_d      = 1'b0;
        d_rdata_d    = d_rdata_q;
        i_rdata_d    = i_rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d      = ISSUE;
                    owner_d      = pick_winner;
                    last_grant_d = pick_winner;
                    if (pick_winner == REQ_D) begin
                        cmd_d.addr  = d_addr;
                        cmd_d.wdata = d_wdata;
                        cmd_d.size  = d_write ? d_size : SZ_WORD;
                        m_read_d    = ~d_write;
                        m_write_d   = d_write;
                    end else begin
                        cmd_d.addr  = i_addr;
                        cmd_d.wdata = '0;
                        cmd_d.size  = SZ_WORD;
                        m_read_d    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(LATENCY);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    if (owner_q == REQ_D) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = m_rdata;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = m_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign d_ack   = d_ack_q;
    assign i_ack   = i_ack_q;
    assign d_rdata = d_rdata_q;
    assign i_rdata = i_rdata_q;
    assign d_stall = d_req & ~d_ack_q;
    assign i_stall = i_req & ~i_ack_q;
    assign m_addr  = cmd_q.addr;
    assign m_wdata = cmd_q.wdata;
    assign m_size  = cmd_q.size;
    assign m_read  = m_read_q;
    assign m_write = m_write_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: vector table of single transactions plus arbitration,
// reset-abort and LATENCY=1 sequences, against a fixed-latency memory model.
module tb_dm_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    always #5 CLK = ~CLK;

    // LATENCY=2 instance
    logic        d_req, d_write, d_ack, d_stall, i_req, i_ack, i_stall;
    logic [31:0] d_addr, d_wdata, d_rdata, i_addr, i_rdata;
    logic [1:0]  d_size, m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_read, m_write, owner;

    // LATENCY=1 instance
    logic        d1_req, d1_write, d1_ack, d1_stall, i1_req, i1_ack, i1_stall;
    logic [31:0] d1_addr, d1_wdata, d1_rdata, i1_addr, i1_rdata;
    logic [1:0]  d1_size, m1_size;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        m1_read, m1_write, owner1;

    dm_port_arbiter #(.LATENCY(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_stall(i_stall),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size), .m_read(m_read), .m_write(m_write),
        .m_rdata(m_rdata), .owner(owner)
    );

    dm_port_arbiter #(.LATENCY(1)) dut1 (
        .CLK(CLK), .RESET(RESET),
        .d_req(d1_req), .d_write(d1_write), .d_addr(d1_addr), .d_wdata(d1_wdata), .d_size(d1_size),
        .d_ack(d1_ack), .d_rdata(d1_rdata), .d_stall(d1_stall),
        .i_req(i1_req), .i_addr(i1_addr), .i_ack(i1_ack), .i_rdata(i1_rdata), .i_stall(i1_stall),
        .m_addr(m1_addr), .m_wdata(m1_wdata), .m_size(m1_size), .m_read(m1_read), .m_write(m1_write),
        .m_rdata(m1_rdata), .owner(owner1)
    );

    // Memory model: data is valid only in the cycle exactly LATENCY after the strobe cycle.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
    endfunction

    int age0, age1;
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            age0 <= 0;
            age1 <= 0;
        end else begin
            if (m_read || m_write) age0 <= 1;
            else if (age0 != 0 && age0 < 20) age0 <= age0 + 1;
            if (m1_read || m1_write) age1 <= 1;
            else if (age1 != 0 && age1 < 20) age1 <= age1 + 1;
        end
    end
    assign m_rdata  = (age0 == 2) ? mem(m_addr)  : 32'hBAD0_BAD0;
    assign m1_rdata = (age1 == 1) ? mem(m1_addr) : 32'hBAD0_BAD0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Trackers filled by run_cycles
    int          iss_d, iss_i, ack_d, ack_i, rd_cnt, wr_cnt;
    logic [31:0] s_addr, s_wdata, got_d, got_i;
    logic [1:0]  s_size;
    logic [15:0] d_stall_mask, i_stall_mask;

    task automatic do_reset();
        RESET  = 1'b0;
        d_req  = 1'b0;
        i_req  = 1'b0;
        i1_req = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
    endtask

    // Called #1 after a posedge (cycle 0); samples mid-cycle, drops each req in its ack cycle.
    task automatic run_cycles(input int max_cyc);
        iss_d = -1; iss_i = -1; ack_d = -1; ack_i = -1;
        rd_cnt = 0; wr_cnt = 0;
        s_addr = '0; s_wdata = '0; s_size = '0; got_d = '0; got_i = '0;
        d_stall_mask = '0; i_stall_mask = '0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge CLK);
            if (m_read)  rd_cnt++;
            if (m_write) wr_cnt++;
            if (m_read || m_write) begin
                if (owner == 1'b0 && iss_d < 0) iss_d = c;
                if (owner == 1'b1 && iss_i < 0) iss_i = c;
                s_addr  = m_addr;
                s_wdata = m_wdata;
                s_size  = m_size;
            end
            if (c < 16) begin
                d_stall_mask[c] = d_stall;
                i_stall_mask[c] = i_stall;
            end
            if (d_ack) begin
                if (ack_d < 0) begin ack_d = c; got_d = d_rdata; end
                d_req = 1'b0;
            end
            if (i_ack) begin
                if (ack_i < 0) begin ack_i = c; got_i = i_rdata; end
                i_req = 1'b0;
            end
            @(posedge CLK);
            #1;
        end
    endtask

    typedef struct {
        logic        is_i;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [31:0] exp_wdata;
        logic [1:0]  exp_size;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];
    logic [5:0] own_seq;
    int n_own;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 2'd0, 32'h0000_0000, 2'd0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0200, 32'h0000_00AB, 2'd1, 32'h0000_00AB, 2'd1, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0400, 32'hFFFF_FFFF, 2'd2, 32'h0000_0000, 2'd0, 32'h5A5A_0400};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0304, 32'h1234_5678, 2'd2, 32'h1234_5678, 2'd2, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0000_0055, 2'd2, 32'h0000_0055, 2'd0, 32'h5A5A_0008};

        d_write = 0; d_addr = 0; d_wdata = 0; d_size = 0; i_addr = 0;
        d1_req = 0; d1_write = 0; d1_addr = 0; d1_wdata = 0; d1_size = 0; i1_addr = 0;
        do_reset();

        // Reset state
        @(negedge CLK);
        chk("reset_strobes_acks_owner", {27'd0, m_read, m_write, d_ack, i_ack, owner}, 32'h0);
        chk("reset_m_addr", m_addr, 32'h0);
        chk("reset_m_wdata_size", m_wdata | {30'd0, m_size}, 32'h0);
        chk("reset_rdata", d_rdata | i_rdata, 32'h0);
        @(posedge CLK); #1;

        // Single-transaction vector table
        foreach (vecs[k]) begin
            d_write = vecs[k].wr; d_wdata = vecs[k].wdata; d_size = vecs[k].size;
            if (vecs[k].is_i) begin
                i_addr = vecs[k].addr; i_req = 1'b1;
            end else begin
                d_addr = vecs[k].addr; d_req = 1'b1;
            end
            run_cycles(10);
            chk($sformatf("v%0d_issue_cycle", k), 32'(vecs[k].is_i ? iss_i : iss_d), 32'd1);
            chk($sformatf("v%0d_ack_cycle", k), 32'(vecs[k].is_i ? ack_i : ack_d), 32'd4);
            chk($sformatf("v%0d_other_ack", k), 32'(vecs[k].is_i ? ack_d : ack_i), 32'hFFFF_FFFF);
            chk($sformatf("v%0d_m_addr", k), s_addr, vecs[k].addr);
            chk($sformatf("v%0d_m_wdata", k), s_wdata, vecs[k].exp_wdata);
            chk($sformatf("v%0d_m_size", k), {30'd0, s_size}, {30'd0, vecs[k].exp_size});
            chk($sformatf("v%0d_rd_wr_strobes", k), 32'(rd_cnt * 16 + wr_cnt),
                vecs[k].wr ? 32'h01 : 32'h10);
            chk($sformatf("v%0d_stall_mask", k),
                {16'd0, vecs[k].is_i ? i_stall_mask : d_stall_mask}, 32'h0000_000F);
            if (!vecs[k].wr) begin
                chk($sformatf("v%0d_rdata", k), vecs[k].is_i ? got_i : got_d, vecs[k].exp_rdata);
                chk($sformatf("v%0d_rdata_held", k), vecs[k].is_i ? i_rdata : d_rdata,
                    vecs[k].exp_rdata);
            end
        end

        // Simultaneous first requests: D wins the first conflict
        d_write = 1'b0; d_addr = 32'h0000_0010; i_addr = 32'h0000_0020;
        do_reset();
        d_req = 1'b1; i_req = 1'b1;
        run_cycles(12);
        chk("sim_d_issue", 32'(iss_d), 32'd1);
        chk("sim_d_ack",   32'(ack_d), 32'd4);
        chk("sim_i_issue", 32'(iss_i), 32'd5);
        chk("sim_i_ack",   32'(ack_i), 32'd8);
        chk("sim_i_stall_mask", {16'd0, i_stall_mask}, 32'h0000_00FF);
        chk("sim_strobes", 32'(rd_cnt + wr_cnt), 32'd2);

        // Continuous contention: six grants must alternate D,I,D,I,D,I
        do_reset();
        d_req = 1'b1; i_req = 1'b1;
        n_own = 0; own_seq = '0;
        for (int c = 0; c < 60 && n_own < 6; c++) begin
            @(negedge CLK);
            if (m_read || m_write) begin
                own_seq[n_own] = owner;
                n_own++;
                if (n_own == 6) begin d_req = 1'b0; i_req = 1'b0; end
            end
            @(posedge CLK); #1;
        end
        repeat (6) @(posedge CLK);
        #1;
        chk("cont_grant_count", 32'(n_own), 32'd6);
        chk("cont_owner_seq", {26'd0, own_seq}, 32'h0000_002A);

        // Reset asserted mid-WAIT aborts; held request restarts after release
        d_addr = 32'h0000_0008;
        do_reset();
        d_req = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        #1;
        chk("rst_wait_ctrl", {27'd0, m_read, m_write, d_ack, i_ack, owner}, 32'h0);
        chk("rst_wait_m_addr", m_addr, 32'h0);
        chk("rst_wait_rdata", d_rdata, 32'h0);
        @(posedge CLK);
        @(posedge CLK); #1;
        RESET = 1'b1;
        run_cycles(10);
        chk("rst_restart_issue", 32'(iss_d), 32'd1);
        chk("rst_restart_ack", 32'(ack_d), 32'd4);
        chk("rst_restart_rdata", got_d, 32'h5A5A_0008);
        chk("rst_restart_strobes", 32'(rd_cnt + wr_cnt), 32'd1);

        // LATENCY=1 instance: I fetch of 0x400
        begin
            int iss1, ack1;
            logic [31:0] got1;
            iss1 = -1; ack1 = -1; got1 = '0;
            i1_addr = 32'h0000_0400;
            i1_req = 1'b1;
            for (int c = 0; c < 8; c++) begin
                @(negedge CLK);
                if (m1_read && iss1 < 0) iss1 = c;
                if (i1_ack) begin
                    if (ack1 < 0) begin ack1 = c; got1 = i1_rdata; end
                    i1_req = 1'b0;
                end
                @(posedge CLK); #1;
            end
            chk("lat1_issue", 32'(iss1), 32'd1);
            chk("lat1_ack", 32'(ack1), 32'd3);
            chk("lat1_rdata", got1, 32'h5A5A_0400);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
